// File: rtl/bz_pkg.sv
// ============================================================================
//  Module      : bz_pkg
//  Description : Shared types and constants for the buzzer melody sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bz_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STRIKE = 3'd2,
        S_HOLD   = 3'd3,
        S_GAP    = 3'd4
    } bz_state_t;

    localparam int DUR_MSB = 7;
    localparam int DUR_LSB = 4;
    localparam int PIT_MSB = 3;
    localparam int PIT_LSB = 0;

    localparam logic [7:0] REST = 8'h00;

    localparam int DEF_TICK  = 1000000;
    localparam int DEF_GAP   = 100000;
    localparam int DEF_SETUP = 2;

    // HOLD length of a note; the +2 absorbs the buzzer's edge-detect latency.
    function automatic logic [23:0] note_cycles(input logic [3:0]  dur,
                                                input logic [23:0] tick);
        return (24'(dur) + 24'd1) * tick + 24'd2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bz_note_mem.sv
// ============================================================================
//  Module      : bz_note_mem
//  Description : Note table, 2**ADDR_W x 8, synchronous write and read; the
//                read register doubles as the sequencer's val output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bz_note_mem
    import bz_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [7:0] r_mem [c_depth];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= REST;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end else if (rd_clr) begin
            r_rd_data <= REST;
        end
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/bz_sequencer.sv
// ============================================================================
//  Module      : bz_sequencer
//  Description : Melody player driving the buzzer start/val interface from a
//                writable note table. Define BZ_SEQ_LOOP_EN to add the loop
//                input for continuous replay.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bz_sequencer
    import bz_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int TICK   = DEF_TICK,
    parameter int GAP    = DEF_GAP,
    parameter int SETUP  = DEF_SETUP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              play,
    input  logic              stop,
`ifdef BZ_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic              start,
    output logic [7:0]        val,
    output logic              busy,
    output logic [ADDR_W-1:0] idx,
    output logic              done
);

    localparam logic [23:0] c_tick     = 24'(TICK);
    localparam logic [23:0] c_gap_m1   = 24'(GAP - 1);
    localparam logic [23:0] c_setup_m1 = 24'(SETUP - 1);

    bz_state_t         r_state, w_state_nxt;
    logic [23:0]       r_cnt, w_cnt_nxt;
    logic [23:0]       r_dur, w_dur_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx_nxt;
    logic [ADDR_W-1:0] r_last, w_last_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_start, w_start_nxt;
    logic              w_rd_en, w_rd_clr;
    logic [7:0]        w_val;
    logic              w_loop;
    logic [ADDR_W-1:0] w_len_last;

`ifdef BZ_SEQ_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    // Any len with the top bit set covers the whole table.
    assign w_len_last = len[ADDR_W] ? '1 : (len[ADDR_W-1:0] - ADDR_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dur   <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dur   <= w_dur_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_start <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - 24'd1) : r_cnt;
        w_dur_nxt   = r_dur;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (play && (len == '0)) begin
                    w_done_nxt = 1'b1;
                end else if (play && !stop) begin
                    w_last_nxt  = w_len_last;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = c_setup_m1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_dur_nxt = note_cycles(w_val[DUR_MSB:DUR_LSB], c_tick);
                if (r_cnt == '0) begin
                    w_state_nxt = S_STRIKE;
                end
            end
            S_STRIKE: begin
                w_cnt_nxt   = r_dur - 24'd1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = c_gap_m1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    if (r_idx == r_last) begin
                        w_done_nxt = 1'b1;
                        w_idx_nxt  = '0;
                        if (w_loop) begin
                            w_cnt_nxt   = c_setup_m1;
                            w_state_nxt = S_LOAD;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_idx_nxt   = r_idx + ADDR_W'(1);
                        w_cnt_nxt   = c_setup_m1;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // stop overrides play and end-of-sequence alike, and never pulses done.
        if (stop && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end

        w_start_nxt = (w_state_nxt == S_STRIKE);
        w_rd_en     = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
        w_rd_clr    = (w_state_nxt == S_GAP) || (w_state_nxt == S_IDLE);
    end

    bz_note_mem #(
        .ADDR_W (ADDR_W)
    ) u_note_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .rd_clr  (w_rd_clr),
        .rd_addr (w_idx_nxt),
        .rd_data (w_val)
    );

    assign start = r_start;
    assign val   = w_val;
    assign busy  = r_busy;
    assign idx   = r_idx;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bz_sequencer.sv
// ============================================================================
//  Module      : tb_bz_sequencer
//  Description : Self-checking bench for bz_sequencer (TICK=10, GAP=3, SETUP=2)
//                against a note-schedule reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bz_sequencer;

    localparam int ADDR_W = 4;
    localparam int TICK   = 10;
    localparam int GAP    = 3;
    localparam int SETUP  = 2;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [4:0] len = '0;
    logic       play = 1'b0;
    logic       stop = 1'b0;
`ifdef BZ_SEQ_LOOP_EN
    logic       loop = 1'b0;
`endif
    logic       start;
    logic [7:0] val;
    logic       busy;
    logic [3:0] idx;
    logic       done;

    bz_sequencer #(
        .ADDR_W (ADDR_W),
        .TICK   (TICK),
        .GAP    (GAP),
        .SETUP  (SETUP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .play    (play),
        .stop    (stop),
`ifdef BZ_SEQ_LOOP_EN
        .loop    (loop),
`endif
        .start   (start),
        .val     (val),
        .busy    (busy),
        .idx     (idx),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: position within the current note's period.
    logic [7:0] sh_mem [DEPTH];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         m_k = 0;
    int         m_p = 0;
    int         m_n = 0;
    logic [7:0] m_byte = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int hold_len(input logic [7:0] b);
        logic [3:0] d;
        d = b[7:4];
        return (int'(d) + 1) * TICK + 2;
    endfunction

    function automatic int period(input logic [7:0] b);
        return SETUP + 1 + hold_len(b) + GAP;
    endfunction

    function automatic logic [14:0] expected_outs();
        logic       e_start;
        logic [7:0] e_val;
        logic [3:0] e_idx;
        e_start = m_busy && (m_p == SETUP);
        e_val   = (m_busy && (m_p < SETUP + 1 + hold_len(m_byte))) ? m_byte : 8'h00;
        e_idx   = m_busy ? 4'(m_k) : 4'd0;
        return {e_start, e_val, m_busy, e_idx, m_done};
    endfunction

    task automatic model_update();
        bit lp;
`ifdef BZ_SEQ_LOOP_EN
        lp = loop;
`else
        lp = 1'b0;
`endif
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_k = 0; m_p = 0;
        end else if (m_busy && stop) begin
            m_busy = 1'b0; m_k = 0; m_p = 0;
        end else if (m_busy) begin
            m_p++;
            if (m_p == period(m_byte)) begin
                m_p = 0;
                if (m_k == m_n - 1) begin
                    m_done = 1'b1;
                    m_k    = 0;
                    if (lp) m_byte = sh_mem[0];
                    else    m_busy = 1'b0;
                end else begin
                    m_k++;
                    m_byte = sh_mem[m_k];
                end
            end
        end else if (play && (len == 0)) begin
            m_done = 1'b1;
        end else if (play && !stop) begin
            m_busy = 1'b1;
            m_n    = (len > DEPTH) ? DEPTH : int'(len);
            m_k    = 0;
            m_p    = 0;
            m_byte = sh_mem[0];
        end
        if (wr_en) sh_mem[wr_addr] = wr_data;
    endtask

    task automatic step();
        logic [14:0] e;
        model_update();
        e = expected_outs();
        @(posedge clk);
        #1;
        cyc++;
        check("outs", {17'd0, start, val, busy, idx, done}, {17'd0, e});
    endtask

    task automatic write_note(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t_s, t_v, t_d, cnt, cnt2, anyb, mx;
        int dq[$];

        rst = 1'b1;
        repeat (3) step();
        check("reset_outs", {17'd0, start, val, busy, idx, done}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_note(4'(i), 8'h00);

        // Two-note directed sequence
        write_note(4'd0, 8'h15);
        write_note(4'd1, 8'h03);
        len = 5'd2; play = 1'b1;
        step(); t0 = cyc; play = 1'b0;
        t_s = -1; t_v = -1; t_d = -1;
        for (int i = 0; i < 100 && t_d < 0; i++) begin
            step();
            if (start && t_s < 0) t_s = cyc - t0;
            if (val == 8'h03 && t_v < 0) t_v = cyc - t0;
            if (done) t_d = cyc - t0;
        end
        check("strike_latency", 32'(t_s), 32'd2);
        check("note1_val_cycle", 32'(t_v), 32'd28);
        check("done_cycle", 32'(t_d), 32'd46);
        step();
        check("busy_after_done", {31'd0, busy}, 32'd0);

        // play held with len=0
        len = 5'd0; play = 1'b1; cnt = 0; anyb = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cnt += int'(done);
            if (busy) anyb = 1;
        end
        play = 1'b0;
        check("len0_done_pulses", 32'(cnt), 32'd5);
        check("len0_busy", 32'(anyb), 32'd0);
        step();

        // stop together with play in the middle of HOLD
        len = 5'd2; play = 1'b1;
        step(); play = 1'b0;
        repeat (10) step();
        stop = 1'b1; play = 1'b1;
        step();
        stop = 1'b0; play = 1'b0;
        check("stop_outs", {17'd0, start, val, busy, idx, done}, 32'd0);
        step();
        check("stop_play_ignored", {31'd0, busy}, 32'd0);

        // Full table of long notes
        for (int i = 0; i < DEPTH; i++) write_note(4'(i), 8'hF1);
        len = 5'd16; play = 1'b1;
        step(); t0 = cyc; play = 1'b0;
        cnt = 0; cnt2 = 0; t_d = -1; mx = 0;
        for (int i = 0; i < 3000 && t_d < 0; i++) begin
            step();
            cnt += int'(start);
            if (int'(idx) > mx) mx = int'(idx);
            if (done) begin cnt2++; t_d = cyc - t0; end
        end
        check("full_strikes", 32'(cnt), 32'd16);
        check("full_done_pulses", 32'(cnt2), 32'd1);
        check("full_done_cycle", 32'(t_d), 32'd2688);
        check("full_max_idx", 32'(mx), 32'd15);
        check("full_idx_wrapped", {28'd0, idx}, 32'd0);

        // Reset during STRIKE, then restart
        len = 5'd2; play = 1'b1;
        step(); play = 1'b0;
        step(); step();
        check("in_strike", {31'd0, start}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outs", {17'd0, start, val, busy, idx, done}, 32'd0);
        play = 1'b1;
        step(); play = 1'b0;
        step(); step();
        check("restart_strike", {27'd0, start, idx}, 32'h10);
        stop = 1'b1; step(); stop = 1'b0;

`ifdef BZ_SEQ_LOOP_EN
        write_note(4'd0, 8'h15);
        write_note(4'd1, 8'h03);
        len = 5'd2; loop = 1'b1; play = 1'b1;
        step(); t0 = cyc; play = 1'b0;
        anyb = 1;
        for (int i = 0; i < 150; i++) begin
            step();
            if (done) dq.push_back(cyc - t0);
            if (!busy) anyb = 0;
        end
        check("loop_done_count", 32'(dq.size()), 32'd3);
        for (int i = 0; i < dq.size(); i++) check("loop_done_at", 32'(dq[i]), 32'(46 * (i + 1)));
        check("loop_busy_held", 32'(anyb), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;
        check("loop_stop", {31'd0, busy}, 32'd0);
        loop = 1'b0;
        step();
`endif

        // Randomized runs against the model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) write_note(4'(i), 8'($urandom));
            len  = 5'($urandom_range(0, 20));
`ifdef BZ_SEQ_LOOP_EN
            loop = 1'($urandom_range(0, 1));
`endif
            play = 1'b1;
            step();
            for (int i = 0; i < 1500; i++) begin
                play  = ($urandom_range(0, 9) == 0);
                stop  = ($urandom_range(0, 299) == 0);
                wr_en = ($urandom_range(0, 7) == 0);
                wr_addr = 4'($urandom);
                wr_data = 8'($urandom);
                if ($urandom_range(0, 49) == 0) len = 5'($urandom_range(0, 20));
                rst = ($urandom_range(0, 999) == 0);
                step();
            end
            play = 1'b0; wr_en = 1'b0; rst = 1'b0;
            stop = 1'b1; step(); stop = 1'b0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bz_sequencer.md
Name: bz_sequencer

Overview:
- Melody player that drives the buzzer controller's `start` / `val[7:0]` interface (initiator side of the buzzer protocol).
- Holds a small writable note table and plays entries 0..len-1 in order.
- For each note it presents `val`, issues a one-cycle `start` strike, then waits out the note's duration and an articulation gap before the next note.
- Sits between the CPU/switch logic and the buzzer block; 10 MHz system clock.

Parameters:
ADDR_W, 4, note-table address width; table depth = 2**ADDR_W
TICK, 1000000, cycles per 0.1 s duration unit (10 MHz)
GAP, 100000, silent cycles between notes (10 ms)
SETUP, 2, cycles `val` is stable before `start` rises (covers the buzzer's registered threshold lookup)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  note-table write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  8  note byte: [7:4] duration code, [3:0] pitch code (0 = rest)
len  in  ADDR_W+1  number of notes to play; sampled on accepted `play`
play  in  1  start playback (level; acted on while idle)
stop  in  1  abort playback
start  out  1  strike pulse to the buzzer
val  out  8  note byte to the buzzer
busy  out  1  high from accepted `play` until the sequence ends or is stopped
idx  out  ADDR_W  index of the current note
done  out  1  one-cycle pulse when the last note's gap completes

Behaviour:
- Reset (sync, active-high):
  - start=0, val=8'h00, busy=0, idx=0, done=0.
  - State IDLE; note table contents undefined.
- Note table write: when wr_en=1, mem[wr_addr] <= wr_data on the clock edge. Writes are allowed in any state.
- Note table read is synchronous; the word is fetched in the first LOAD cycle.
- IDLE:
  - play=1, stop=0 and len!=0: latch n = min(len, 2**ADDR_W), idx<=0, busy<=1, go to LOAD.
  - play=1 and len==0: done pulses next cycle, busy stays 0.
- LOAD (SETUP cycles):
  - val <= mem[idx].
  - Duration count D = (val[7:4]+1)*TICK+2, computed to 24 bits. The +2 covers the buzzer's edge-detect latency.
- STRIKE (1 cycle): start=1. `start` is 0 in every other state, so the buzzer always sees a clean rising edge.
- HOLD (D cycles): `val` held; no action.
- GAP (GAP cycles): val <= 8'h00, which silences the buzzer's pitch output.
- After GAP:
  - If idx==n-1: done=1 for one cycle, busy<=0, idx<=0, go to IDLE.
  - Otherwise idx<=idx+1, go to LOAD.
- Per-note period = SETUP+1+D+GAP cycles exactly.
- stop=1 in any non-IDLE state:
  - Next cycle: IDLE, start=0, val=8'h00, busy=0, idx=0.
  - done is not pulsed.
  - stop takes priority over a simultaneous play or end-of-sequence.
- play while busy is ignored; len changes while busy are ignored.
- A write to an entry not yet loaded takes effect when that entry is loaded. A write to the current entry does not affect the playing note.
- Rest notes (pitch 0) still strike and time normally.

Optional Feature:
- Macro: BZ_SEQ_LOOP_EN.
- Defined:
  - Adds input port `loop` (1 bit).
  - At end of GAP for idx==n-1 with loop=1: done pulses, idx<=0, return to LOAD; busy stays 1.
  - With loop=0, behaves as if the macro were undefined.
  - Only `stop` exits a loop.
- Undefined: no `loop` port; the sequence always ends in IDLE.

Decomposition:
- Shared package bz_pkg:
  - state encoding (IDLE, LOAD, STRIKE, HOLD, GAP)
  - note field positions (DUR_MSB=7, DUR_LSB=4, PIT_MSB=3, PIT_LSB=0)
  - REST byte 8'h00
  - default TICK and GAP constants
- Sub-module bz_note_mem: 2**ADDR_W x 8, synchronous write, synchronous read.
- FSM and duration counter stay in bz_sequencer.

Test Plan (TICK=10, GAP=3, SETUP=2):
- Write mem[0]=8'h15, mem[1]=8'h03; len=2, pulse play.
  - -> start high 2 cycles after play accept; note 0 lasts 2+1+22+3=28 cycles.
  - -> val=8'h03 at cycle 28; done pulse after 2+1+12+3=18 more cycles; busy low afterwards.
- play held high with len=0.
  - -> busy never rises; done pulses each cycle play is seen in IDLE.
- Mid-HOLD of note 0, assert stop together with play.
  - -> next cycle: busy=0, val=00, start=0, idx=0, no done; play ignored that cycle.
- len=16, all entries 8'hF1.
  - -> 16 strikes, each HOLD 162 cycles; idx wraps 15->0 only at the end; one done pulse.
- Assert rst mid-STRIKE.
  - -> next cycle all outputs at reset values; a subsequent play restarts from idx 0.
- With BZ_SEQ_LOOP_EN, loop=1, len=2.
  - -> done pulses every 46 cycles, busy stays high; stop ends playback within 1 cycle.
